afifo_rd_stream: RTL
====================

Name: afifo_rd_stream

Overview:
- Read-side consumer for the async FIFO, in the rclk domain.
- Pops entries from FIFO memory through the read-pointer controller (rincr/rempty), absorbs the 1-cycle synchronous memory read latency, and presents data as a valid/ready stream.
- Built so that a continuously-ready sink sees 1 word/cycle.
- Optionally reports the read-side fill level from the synchronized gray pointers.

Parameters:
- DATA_W, 8, FIFO word width.
- ADDR_LEN, 8, FIFO address width; pointers are ADDR_LEN+1 bits.
- OBUF_DEPTH, 3, output skid-buffer entries; legal range 2..4; 3 or more gives full throughput.
- AE_THRESH, 2, almost-empty threshold in words (optional feature only).

Ports:
- rclk  in  1  read clock.
- rrst_n  in  1  asynchronous, active-low reset.
- rempty_i  in  1  registered empty flag from the read-pointer controller.
- rdata_i  in  DATA_W  memory read data; valid one cycle after the address was presented.
- rincr_o  out  1  pop request to the read-pointer controller.
- m_valid_o  out  1  output stream valid.
- m_data_o  out  DATA_W  output stream data.
- m_ready_i  in  1  sink ready.
- rptr_i  in  ADDR_LEN+1  gray read pointer (optional feature only).
- w2rptr_sync_i  in  ADDR_LEN+1  gray write pointer, already synchronized into rclk (optional feature only).
- rlevel_o  out  ADDR_LEN+1  words in the FIFO as seen by the read side (optional feature only).
- ralmost_empty_o  out  1  asserted when rlevel_o <= AE_THRESH (optional feature only).

Behaviour:
- Reset: rincr_o=0, m_valid_o=0, m_data_o=0, occupancy=0, inflight=0, rlevel_o=0, ralmost_empty_o=1.
- Reset mid-operation empties the output buffer and discards in-flight data.
- Issue rule: rincr_o = !rempty_i && (occ + inflight < OBUF_DEPTH).
  - Purely combinational from registered state; no path from m_ready_i to rincr_o.
- inflight (1 bit):
  - Set on the cycle after rincr_o=1, else cleared.
  - When inflight=1, rdata_i is written into the output buffer that cycle.
- Output buffer:
  - Circular, OBUF_DEPTH entries, ceil(log2(OBUF_DEPTH)) bit pointers.
  - Pointers wrap modulo OBUF_DEPTH; a non-power-of-2 depth uses an explicit compare-and-clear.
  - m_valid_o = (occ != 0); m_data_o = head entry; pop on m_valid_o && m_ready_i.
- Simultaneous write and pop: occ unchanged, both pointers advance.
  - Write into a full buffer cannot occur by construction; the bench asserts this.
- Ordering: strict FIFO; data emerges in the same order it was popped.
- Latency:
  - rempty_i falls at cycle t, rincr_o=1 at t, data captured at t+1, m_valid_o=1 at t+2.
- Stream rule: once m_valid_o=1, m_data_o stays stable until accepted.
- Stall: with m_ready_i=0, at most OBUF_DEPTH words are popped, then rincr_o stays 0.
- Empty: rempty_i=1 gives rincr_o=0; buffered data continues to drain.

Optional Feature:
- Macro: AFIFO_RD_LEVEL_EN.
- Defined:
  - rptr_i and w2rptr_sync_i are gray-to-binary converted.
  - rlevel_o <= wbin - rbin, modulo 2^(ADDR_LEN+1), registered, 1 cycle latency. This handles pointer wrap: e.g. w=0x002, r=0x1FE gives 4 with ADDR_LEN=8.
  - ralmost_empty_o <= (wbin - rbin) <= AE_THRESH, registered.
- Not defined:
  - rptr_i, w2rptr_sync_i, rlevel_o and ralmost_empty_o are absent from the port list.
  - No conversion logic is built.

Decomposition:
- Shared package afifo_pkg holds:
  - gray2bin function, parameterized width.
  - bin2gray function.
  - Default ADDR_LEN and DATA_W constants.
- One sub-module: afifo_obuf, the OBUF_DEPTH circular skid buffer with push/pop/occ.
  - afifo_rd_stream instantiates it and adds the issue/inflight control and the level logic.

Test Plan:
- Reset release with rempty_i=1: rincr_o=0, m_valid_o=0 for 10 cycles; ralmost_empty_o=1.
- Model FIFO preloaded with 0x11..0x18, rempty_i=0, m_ready_i=1: first m_valid_o 2 cycles after the first rincr_o, then 8 consecutive beats 0x11..0x18 with no bubbles.
- m_ready_i=0 with 10 words available: exactly 3 rincr_o pulses, then rincr_o held 0. Raise m_ready_i: words delivered in order, none lost or duplicated.
- Random m_ready_i (50%) and random rempty_i, 2000 words: scoreboard order match; occ+inflight never exceeds 3.
- Assert rrst_n low with occ=2 and inflight=1: next cycle m_valid_o=0. After release, no stale word appears.
- AFIFO_RD_LEVEL_EN, ADDR_LEN=8, w gray=bin2gray(0x002), r gray=bin2gray(0x1FE): rlevel_o=4, ralmost_empty_o=0. Then w=bin2gray(0x1FF): rlevel_o=1, ralmost_empty_o=1.

Source files
------------

// File: rtl/afifo_pkg.sv
// afifo_pkg: shared constants and gray-code helpers for the async FIFO.
// The helpers work on a GRAY_MAX_W-bit container. Callers zero-extend narrower
// pointers into it and truncate the result. Leading zeros do not change either
// conversion, so one function serves every pointer width up to GRAY_MAX_W.
package afifo_pkg;

   localparam int DEFAULT_DATA_W   = 8;
   localparam int DEFAULT_ADDR_LEN = 8;
   localparam int GRAY_MAX_W       = 32;

   // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
      logic [GRAY_MAX_W-1:0] bin;
      bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

   // Binary to gray.
   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/afifo_obuf.sv
// afifo_obuf: DEPTH-entry circular skid buffer with push/pop and an occupancy count.
// A pop is ignored while the buffer is empty. The caller guarantees that a push
// never targets a full buffer. A push and a pop in the same cycle advance both
// pointers and leave the occupancy unchanged.
module afifo_obuf
   import afifo_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int DEPTH  = 3
) (
   input  logic                       rclk,
   input  logic                       rrst_n,
   input  logic                       push_i,
   input  logic [DATA_W-1:0]          push_data_i,
   input  logic                       pop_i,
   output logic [$clog2(DEPTH+1)-1:0] occ_o,
   output logic                       valid_o,
   output logic [DATA_W-1:0]          data_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic              do_pop;

   // Wrap by compare-and-clear so that non-power-of-two depths stay in range.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // Next state for the storage, both pointers and the occupancy.
   always_comb begin
      // NOTE: every signal gets a default before any branch; otherwise a path that skips it infers a latch.
      do_pop   = pop_i && (occ_q != '0);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push_i) begin
         mem_d[wr_ptr_q] = push_data_i;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push_i, do_pop})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
   end

   // State registers, with the storage cleared so that the idle head reads as zero.
   always_ff @(posedge rclk or negedge rrst_n) begin
      // NOTE: sequential state uses non-blocking (<=) so that every flop samples pre-edge values.
      if (!rrst_n) begin
         // NOTE: the array is reset deliberately. It is tiny, and reset must drive m_data_o to zero.
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   assign occ_o   = occ_q;
   assign valid_o = (occ_q != '0);
   assign data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/afifo_rd_stream.sv
// afifo_rd_stream: rclk-domain consumer for the async FIFO.
// The block pops words through rincr_o/rempty_i and absorbs the one-cycle memory
// read latency with an in-flight flag. It presents the data as a valid/ready stream.
// A buffer of OBUF_DEPTH >= 3 entries sustains one word per cycle into a sink
// that is always ready. rincr_o depends only on registered state and rempty_i,
// never on m_ready_i.
// Optional: define AFIFO_RD_LEVEL_EN to add rptr_i/w2rptr_sync_i inputs and a
// registered read-side fill level (rlevel_o) with an almost-empty flag.
module afifo_rd_stream
   import afifo_pkg::*;
#(
   parameter int DATA_W     = DEFAULT_DATA_W,
   parameter int OBUF_DEPTH = 3
`ifdef AFIFO_RD_LEVEL_EN
   ,
   parameter int ADDR_LEN   = DEFAULT_ADDR_LEN,
   parameter int AE_THRESH  = 2
`endif
) (
   input  logic              rclk,
   input  logic              rrst_n,
   input  logic              rempty_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic              rincr_o,
   output logic              m_valid_o,
   output logic [DATA_W-1:0] m_data_o,
   input  logic              m_ready_i
`ifdef AFIFO_RD_LEVEL_EN
   ,
   input  logic [ADDR_LEN:0] rptr_i,
   input  logic [ADDR_LEN:0] w2rptr_sync_i,
   output logic [ADDR_LEN:0] rlevel_o,
   output logic              ralmost_empty_o
`endif
);

   localparam int OCC_W = $clog2(OBUF_DEPTH + 1);

   logic [OCC_W-1:0] occ;
   logic [OCC_W:0]   pending;
   logic             inflight_q, inflight_d;

   afifo_obuf #(
      .DATA_W (DATA_W),
      .DEPTH  (OBUF_DEPTH)
   ) u_obuf (
      .rclk        (rclk),
      .rrst_n      (rrst_n),
      .push_i      (inflight_q),
      .push_data_i (rdata_i),
      .pop_i       (m_ready_i),
      .occ_o       (occ),
      .valid_o     (m_valid_o),
      .data_o      (m_data_o)
   );

   // Pop only when the buffer can hold every word already requested plus this one.
   always_comb begin
      pending    = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q};
      rincr_o    = !rempty_i && (pending < (OCC_W + 1)'(OBUF_DEPTH));
      inflight_d = rincr_o;
   end

   // inflight marks the cycle in which rdata_i holds the word popped one cycle earlier.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
      end
   end

`ifdef AFIFO_RD_LEVEL_EN
   localparam int PTR_W = ADDR_LEN + 1;

   logic [ADDR_LEN:0] rbin, wbin;
   logic [ADDR_LEN:0] rlevel_q, rlevel_d;
   logic              ralmost_empty_q, ralmost_empty_d;

   // Convert both gray pointers. The modular difference handles pointer wrap for free.
   always_comb begin
      rbin            = PTR_W'(gray2bin(GRAY_MAX_W'(rptr_i)));
      wbin            = PTR_W'(gray2bin(GRAY_MAX_W'(w2rptr_sync_i)));
      rlevel_d        = wbin - rbin;
      ralmost_empty_d = (rlevel_d <= PTR_W'(AE_THRESH));
   end

   // Register the level and the almost-empty flag. An idle FIFO reads as empty.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rlevel_q        <= '0;
         ralmost_empty_q <= 1'b1;
      end else begin
         rlevel_q        <= rlevel_d;
         ralmost_empty_q <= ralmost_empty_d;
      end
   end

   assign rlevel_o        = rlevel_q;
   assign ralmost_empty_o = ralmost_empty_q;
`endif

endmodule
